// File: rtl/act_stream_receiver.sv
// Activation-side receiver: pulls accumulator beats from the output buffer, buffers them in a
// skid FIFO, requantizes each 8-lane beat to int8 and presents a 64-bit valid/ready stream.
`ifndef MAC_OUTPUT_WIDTH
`define MAC_OUTPUT_WIDTH 36
`endif

module act_stream_receiver #(
    parameter int MAC_OUTPUT_WIDTH = `MAC_OUTPUT_WIDTH,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                          system_clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [5:0]                    shift,
    input  logic                          relu_en,
    output logic                          pull_out_req,
    input  logic                          pull_finish,
    output logic                          pull_where,
    output logic                          pull_ready,
    input  logic [8*MAC_OUTPUT_WIDTH-1:0] data_for_act,
    input  logic                          data_for_act_valid,
    output logic [63:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   beat_count,
    output logic                          overflow_err,
    output logic [2:0]                    dbg_state
);
    // Output handshake: a word transfers on a rising edge where out_valid and out_ready are both 1;
    // while out_valid is 1 and out_ready is 0 the word and every pipeline stage hold still.
    localparam int W  = MAC_OUTPUT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [W:0] SAT_HI = (W+1)'(127);
    localparam logic signed [W:0] SAT_LO = (W+1)'(-128);

    typedef enum logic [2:0] {IDLE, REQ, ARM, PULL, DRAIN} state_t;
    state_t state_q, state_d;

    logic [5:0]           shift_q;
    logic                 relu_q;
    logic [8*W-1:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q, fifo_count, count_next;
    logic                 fifo_empty, fifo_full, push, pop, drop, stall, advance;
    logic [8*W-1:0]       fifo_head;
    logic                 s1_v_q, s2_v_q, out_v_q;
    logic [8*(W+1)-1:0]   s1_q, s1_d;
    logic [63:0]          s2_q, s2_d, out_q;
    logic signed [W:0]    lane_x, lane_sum, rnd, lane_r;
    logic                 pull_ready_q, ready_d, done_q, done_d, drain_empty, start_acc;
    logic [15:0]          beat_count_q;
    logic                 overflow_q;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign stall      = out_v_q & ~out_ready;
    assign advance    = ~stall;
    assign pop        = advance & ~fifo_empty;
    // A full FIFO still accepts a beat when the head leaves on the same edge.
    assign push       = data_for_act_valid & (~fifo_full | pop);
    assign drop       = data_for_act_valid & ~push;
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
    assign start_acc  = start & (state_q == IDLE);

    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_next = fifo_count - 1'b1;
        end
    end

    // Round-half-up then arithmetic shift, carried at W+1 bits so the rounding add cannot wrap.
    always_comb begin
        s1_d     = '0;
        lane_x   = '0;
        lane_sum = '0;
        rnd      = (shift_q == 6'd0) ? '0 : ((W+1)'(1) << (shift_q - 6'd1));
        for (int k = 0; k < 8; k++) begin
            lane_x   = {fifo_head[k*W+W-1], fifo_head[k*W +: W]};
            lane_sum = lane_x + rnd;
            s1_d[k*(W+1) +: (W+1)] = lane_sum >>> shift_q;
        end
    end

    always_comb begin
        s2_d   = '0;
        lane_r = '0;
        for (int k = 0; k < 8; k++) begin
            lane_r = s1_q[k*(W+1) +: (W+1)];
            if (relu_q && lane_r[W]) begin
                lane_r = '0;
            end
            if (lane_r > SAT_HI) begin
                s2_d[k*8 +: 8] = 8'h7F;
            end else if (lane_r < SAT_LO) begin
                s2_d[k*8 +: 8] = 8'h80;
            end else begin
                s2_d[k*8 +: 8] = lane_r[7:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        drain_empty = fifo_empty & ~s1_v_q & ~s2_v_q & ~out_v_q & ~data_for_act_valid;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     state_d = ARM;
            ARM:     state_d = PULL;
            PULL:    if (pull_finish) state_d = DRAIN;
            DRAIN: begin
                if (drain_empty) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Headroom of 4: three beats already in the read pipe plus this registered ready.
        ready_d = (state_d == PULL) && (int'(count_next) + 4 <= FIFO_DEPTH);
    end

    always_ff @(posedge system_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_for_act;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            relu_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            out_v_q      <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            out_q        <= '0;
            pull_ready_q <= 1'b0;
            done_q       <= 1'b0;
            beat_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pull_ready_q <= ready_d;
            done_q       <= done_d;
            if (start_acc) begin
                shift_q <= shift;
                relu_q  <= relu_en;
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (advance) begin
                s1_v_q  <= pop;
                s2_v_q  <= s1_v_q;
                out_v_q <= s2_v_q;
                if (pop)    s1_q  <= s1_d;
                if (s1_v_q) s2_q  <= s2_d;
                if (s2_v_q) out_q <= s2_q;
            end
            if (start_acc) begin
                beat_count_q <= '0;
                overflow_q   <= 1'b0;
            end else begin
                if (push && beat_count_q != 16'hFFFF) beat_count_q <= beat_count_q + 16'd1;
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    assign pull_out_req = (state_q == REQ);
    assign pull_where   = 1'b1;
    assign pull_ready   = pull_ready_q;
    assign out_data     = out_q;
    assign out_valid    = out_v_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign beat_count   = beat_count_q;
    assign overflow_err = overflow_q;
    assign dbg_state    = state_q;

endmodule
